// File: rtl/regwb_pkg.sv
// Shared register-file constants, the write-back request record and the
// legality rule used by the regwb_arbiter write-back path.
package regwb_pkg;

    localparam logic [2:0] REG_C0         = 3'd5;
    localparam logic [2:0] REG_ZERO       = 3'd6;
    localparam int         NUM_GEN_REGS   = 7;
    localparam int         NUM_LABEL_REGS = 6;

    typedef struct packed {
        logic [2:0] rd;
        logic [7:0] data;
        logic       cond;
        logic       label;
    } wb_req_t;

    // The zero register and the index past the general file are never writable.
    function automatic logic is_legal_write(input wb_req_t req);
        if (req.label)
            return int'(req.rd) < NUM_LABEL_REGS;
        else
            return (req.rd != REG_ZERO) && (int'(req.rd) < NUM_GEN_REGS);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a single priority flop selects the winner
// on contention and then flips to favour the side that lost.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       hold,
    output logic [1:0] gnt
);

    logic r_prio;

    always_comb begin
        gnt = 2'b00;
        if (!hold && !rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = r_prio ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // r_prio = 0 favours req[0]; only a real grant moves it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_prio <= 1'b0;
        else if (gnt[0])
            r_prio <= 1'b1;
        else if (gnt[1])
            r_prio <= 1'b0;
    end

endmodule

// File: rtl/regwb_arbiter.sv
// Write-back arbiter between the ALU and memory-load paths into the register file.
// Optional saturating conflict counter enabled by `define REGWB_CONFLICT_CNT_EN.
module regwb_arbiter
    import regwb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_valid,
    output logic       alu_ready,
    input  logic [2:0] alu_rd,
    input  logic [7:0] alu_data,
    input  logic       alu_cond,
    input  logic       alu_label,
    input  logic       mem_valid,
    output logic       mem_ready,
    input  logic [2:0] mem_rd,
    input  logic [7:0] mem_data,
    input  logic       mem_cond,
    input  logic       mem_label,
    input  logic       hold,
    output logic       reg_write,
    output logic       label_write,
    output logic [2:0] rd,
    output logic [7:0] write_data,
    output logic       condition_bit,
    output logic       wr_err
`ifdef REGWB_CONFLICT_CNT_EN
    ,
    output logic [7:0] conflict_cnt
`endif
);

    logic [1:0] w_gnt;
    logic       w_accept;
    logic       w_legal;
    wb_req_t    w_alu_req;
    wb_req_t    w_mem_req;
    wb_req_t    w_sel;

    logic       r_reg_write;
    logic       r_label_write;
    logic [2:0] r_rd;
    logic [7:0] r_data;
    logic       r_cond;
    logic       r_wr_err;

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  ({mem_valid, alu_valid}),
        .hold (hold),
        .gnt  (w_gnt)
    );

    assign alu_ready = w_gnt[0];
    assign mem_ready = w_gnt[1];
    assign w_accept  = |w_gnt;

    assign w_alu_req = '{rd: alu_rd, data: alu_data, cond: alu_cond, label: alu_label};
    assign w_mem_req = '{rd: mem_rd, data: mem_data, cond: mem_cond, label: mem_label};
    assign w_sel     = w_gnt[1] ? w_mem_req : w_alu_req;
    assign w_legal   = is_legal_write(w_sel);

    // Strobes last one cycle; data fields only move on a legal write so they
    // keep showing the last real write while the strobes are idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg_write   <= 1'b0;
            r_label_write <= 1'b0;
            r_rd          <= '0;
            r_data        <= '0;
            r_cond        <= 1'b0;
            r_wr_err      <= 1'b0;
        end else begin
            r_reg_write   <= 1'b0;
            r_label_write <= 1'b0;
            r_wr_err      <= 1'b0;
            if (w_accept) begin
                if (w_legal) begin
                    r_reg_write   <= !w_sel.label;
                    r_label_write <= w_sel.label;
                    r_rd          <= w_sel.rd;
                    r_data        <= w_sel.data;
                    r_cond        <= w_sel.cond;
                end else begin
                    r_wr_err      <= 1'b1;
                end
            end
        end
    end

    assign reg_write     = r_reg_write;
    assign label_write   = r_label_write;
    assign rd            = r_rd;
    assign write_data    = r_data;
    assign condition_bit = r_cond;
    assign wr_err        = r_wr_err;

`ifdef REGWB_CONFLICT_CNT_EN
    logic       w_conflict;
    logic [7:0] r_conflict_cnt;

    assign w_conflict = !hold && alu_valid && mem_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_conflict_cnt <= '0;
        else if (w_conflict && (r_conflict_cnt != 8'hFF))
            r_conflict_cnt <= r_conflict_cnt + 8'd1;
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// Directed self-checking bench for regwb_arbiter; define REGWB_CONFLICT_CNT_EN
// to also exercise the conflict counter.
module tb_regwb_arbiter;

    logic       clk;
    logic       rst;
    logic       alu_valid, alu_ready, alu_cond, alu_label;
    logic [2:0] alu_rd;
    logic [7:0] alu_data;
    logic       mem_valid, mem_ready, mem_cond, mem_label;
    logic [2:0] mem_rd;
    logic [7:0] mem_data;
    logic       hold;
    logic       reg_write, label_write, condition_bit, wr_err;
    logic [2:0] rd;
    logic [7:0] write_data;
`ifdef REGWB_CONFLICT_CNT_EN
    logic [7:0] conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    regwb_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .alu_cond      (alu_cond),
        .alu_label     (alu_label),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .mem_cond      (mem_cond),
        .mem_label     (mem_label),
        .hold          (hold),
        .reg_write     (reg_write),
        .label_write   (label_write),
        .rd            (rd),
        .write_data    (write_data),
        .condition_bit (condition_bit),
        .wr_err        (wr_err)
`ifdef REGWB_CONFLICT_CNT_EN
        ,
        .conflict_cnt  (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0; alu_cond = 0; alu_label = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0; mem_cond = 0; mem_label = 0;
        hold = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1;
        #2;
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        alu_valid = 1;
        mem_valid = 1;
        rst = 1;
        #2;
        checks++;
        if ({alu_ready, mem_ready} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_ready got %b want 00", {alu_ready, mem_ready});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({reg_write, label_write, wr_err, rd, write_data, condition_bit} !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got rw=%b lw=%b err=%b rd=%0d wd=%h c=%b want all 0",
                     reg_write, label_write, wr_err, rd, write_data, condition_bit);
        end
`ifdef REGWB_CONFLICT_CNT_EN
        checks++;
        if (conflict_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_conflict got %0d want 0", conflict_cnt);
        end
`endif
        @(negedge clk);
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_single_alu();
        @(negedge clk);
        alu_valid = 1; alu_rd = 3'd2; alu_data = 8'h5A; alu_cond = 1; alu_label = 0;
        #1;
        checks++;
        if ({alu_ready, mem_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL single_ready got %b want 10", {alu_ready, mem_ready});
        end
        @(posedge clk);
        #1;
        clear_inputs();
        checks++;
        if ({reg_write, label_write, rd, write_data, condition_bit} !== {1'b1, 1'b0, 3'd2, 8'h5A, 1'b1}) begin
            errors++;
            $display("[TB] FAIL single_write got rw=%b lw=%b rd=%0d wd=%h c=%b want 1 0 2 5a 1",
                     reg_write, label_write, rd, write_data, condition_bit);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({reg_write, rd, write_data} !== {1'b0, 3'd2, 8'h5A}) begin
            errors++;
            $display("[TB] FAIL single_idle_hold got rw=%b rd=%0d wd=%h want 0 2 5a",
                     reg_write, rd, write_data);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] exp_ready [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        pulse_reset();
        @(negedge clk);
        alu_valid = 1; alu_rd = 3'd1; alu_data = 8'hA1; alu_cond = 1;
        mem_valid = 1; mem_rd = 3'd4; mem_data = 8'hB2; mem_cond = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({alu_ready, mem_ready} !== exp_ready[i]) begin
                errors++;
                $display("[TB] FAIL alt_ready[%0d] got %b want %b", i, {alu_ready, mem_ready}, exp_ready[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (exp_ready[i][1]) begin
                if ({reg_write, rd, write_data, condition_bit} !== {1'b1, 3'd1, 8'hA1, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL alt_write[%0d] got rw=%b rd=%0d wd=%h c=%b want 1 1 a1 1",
                             i, reg_write, rd, write_data, condition_bit);
                end
            end else begin
                if ({reg_write, rd, write_data, condition_bit} !== {1'b1, 3'd4, 8'hB2, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL alt_write[%0d] got rw=%b rd=%0d wd=%h c=%b want 1 4 b2 0",
                             i, reg_write, rd, write_data, condition_bit);
                end
            end
        end
        clear_inputs();
`ifdef REGWB_CONFLICT_CNT_EN
        checks++;
        if (conflict_cnt !== 8'd4) begin
            errors++;
            $display("[TB] FAIL alt_conflict got %0d want 4", conflict_cnt);
        end
`endif
    endtask

    task automatic test_label_and_illegal();
        pulse_reset();
        @(negedge clk);
        mem_valid = 1; mem_label = 1; mem_rd = 3'd3; mem_data = 8'h11; mem_cond = 1;
        #1;
        checks++;
        if ({alu_ready, mem_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL label_ready got %b want 01", {alu_ready, mem_ready});
        end
        @(posedge clk);
        #1;
        mem_rd = 3'd6; mem_data = 8'h22;
        checks++;
        if ({label_write, reg_write, wr_err, rd, write_data} !== {1'b1, 1'b0, 1'b0, 3'd3, 8'h11}) begin
            errors++;
            $display("[TB] FAIL label_write got lw=%b rw=%b err=%b rd=%0d wd=%h want 1 0 0 3 11",
                     label_write, reg_write, wr_err, rd, write_data);
        end
        @(posedge clk);
        #1;
        clear_inputs();
        alu_valid = 1; alu_rd = 3'd7; alu_data = 8'h33;
        checks++;
        if ({label_write, reg_write, wr_err, write_data} !== {1'b0, 1'b0, 1'b1, 8'h11}) begin
            errors++;
            $display("[TB] FAIL label_rd6 got lw=%b rw=%b err=%b wd=%h want 0 0 1 11",
                     label_write, reg_write, wr_err, write_data);
        end
        @(posedge clk);
        #1;
        alu_rd = 3'd6; alu_data = 8'h44;
        checks++;
        if ({reg_write, label_write, wr_err} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL gen_rd7 got rw=%b lw=%b err=%b want 0 0 1", reg_write, label_write, wr_err);
        end
        @(posedge clk);
        #1;
        alu_rd = 3'd5; alu_data = 8'h55; alu_cond = 0;
        checks++;
        if ({reg_write, label_write, wr_err, write_data} !== {1'b0, 1'b0, 1'b1, 8'h11}) begin
            errors++;
            $display("[TB] FAIL gen_rd6 got rw=%b lw=%b err=%b wd=%h want 0 0 1 11",
                     reg_write, label_write, wr_err, write_data);
        end
        @(posedge clk);
        #1;
        clear_inputs();
        checks++;
        if ({reg_write, wr_err, rd, write_data, condition_bit} !== {1'b1, 1'b0, 3'd5, 8'h55, 1'b0}) begin
            errors++;
            $display("[TB] FAIL gen_rd5 got rw=%b err=%b rd=%0d wd=%h c=%b want 1 0 5 55 0",
                     reg_write, wr_err, rd, write_data, condition_bit);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({reg_write, label_write, wr_err} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL idle_after_rd5 got rw=%b lw=%b err=%b want 000", reg_write, label_write, wr_err);
        end
    endtask

    task automatic test_hold();
        pulse_reset();
        @(negedge clk);
        hold = 1;
        alu_valid = 1; alu_rd = 3'd1; alu_data = 8'h66;
        mem_valid = 1; mem_rd = 3'd2; mem_data = 8'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({alu_ready, mem_ready} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL hold_ready[%0d] got %b want 00", i, {alu_ready, mem_ready});
            end
            @(posedge clk);
            #1;
            checks++;
            if ({reg_write, label_write} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL hold_strobe[%0d] got rw=%b lw=%b want 0 0", i, reg_write, label_write);
            end
        end
`ifdef REGWB_CONFLICT_CNT_EN
        checks++;
        if (conflict_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL hold_conflict got %0d want 0", conflict_cnt);
        end
`endif
        @(negedge clk);
        hold = 0;
        #1;
        checks++;
        if ({alu_ready, mem_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL hold_release got %b want 10", {alu_ready, mem_ready});
        end
        @(posedge clk);
        #1;
        clear_inputs();
        checks++;
        if ({reg_write, write_data} !== {1'b1, 8'h66}) begin
            errors++;
            $display("[TB] FAIL hold_release_write got rw=%b wd=%h want 1 66", reg_write, write_data);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        alu_valid = 1; alu_rd = 3'd4; alu_data = 8'h77; alu_cond = 1;
        @(posedge clk);
        #1;
        mem_valid = 1;
        checks++;
        if (reg_write !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_pre got rw=%b want 1", reg_write);
        end
        #2;
        rst = 1;
        #1;
        checks++;
        if ({reg_write, rd, write_data, condition_bit, alu_ready, mem_ready} !== 14'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset got rw=%b rd=%0d wd=%h c=%b rdy=%b%b want all 0",
                     reg_write, rd, write_data, condition_bit, alu_ready, mem_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({reg_write, write_data} !== 9'h0) begin
            errors++;
            $display("[TB] FAIL mid_drop got rw=%b wd=%h want 0 00", reg_write, write_data);
        end
        @(negedge clk);
        rst = 0;
        clear_inputs();
    endtask

`ifdef REGWB_CONFLICT_CNT_EN
    task automatic test_saturate();
        pulse_reset();
        @(negedge clk);
        alu_valid = 1; mem_valid = 1;
        repeat (300) @(posedge clk);
        #1;
        clear_inputs();
        checks++;
        if (conflict_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL saturate got %0d want 255", conflict_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_alu();
        test_alternate();
        test_label_and_illegal();
        test_hold();
        test_reset_mid();
`ifdef REGWB_CONFLICT_CNT_EN
        test_saturate();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
